// File: rtl/write_back_ctrl_pkg.sv
// wb_pkg: shared encodings for the write-back controller.
//   - opcode values of the instructions the controller decodes
//   - REG_SEL_* / R7_SEL_* source codes; their order matches the write-back muxes
//   - ADD/NDU condition field codes
//   - FSM state type
//   - cond_pass(): evaluates a condition field against the execute flags
package wb_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  // General register write-source mux ordering
  localparam logic [1:0] REG_SEL_MEM   = 2'd0;
  localparam logic [1:0] REG_SEL_ALU   = 2'd1;
  localparam logic [1:0] REG_SEL_IMM   = 2'd2;
  localparam logic [1:0] REG_SEL_PCINC = 2'd3;

  // R7 write-source mux ordering
  localparam logic [1:0] R7_SEL_IMM   = 2'd0;
  localparam logic [1:0] R7_SEL_MEM   = 2'd1;
  localparam logic [1:0] R7_SEL_PCIMM = 2'd2;
  localparam logic [1:0] R7_SEL_ALU   = 2'd3;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_CARRY  = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LM   = 1'b1
  } wb_state_e;

  function automatic logic cond_pass(input logic [1:0] c, input logic cf, input logic zf);
    case (c)
      COND_ALWAYS: return 1'b1;
      COND_ZERO:   return zf;
      COND_CARRY:  return cf;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/write_back_ctrl_if.sv
// write_back_ctrl_if: instruction handshake from decode/execute plus the
// select/strobe bundle towards the write-back muxes and register file.
//   master: instruction source (drives in_valid/opcode/cond/rd/reg_list/flags)
//   slave : write_back_ctrl (drives in_ready and all write-back controls)
interface write_back_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [1:0] cond;
  logic [2:0] rd;
  logic [7:0] reg_list;
  logic       carry_flag;
  logic       zero_flag;
  logic [1:0] reg_select;
  logic [1:0] r7_select;
  logic       reg_write;
  logic [2:0] reg_addr;
  logic       r7_write;
  logic [2:0] mem_offset;
  logic       lm_done;

  modport master (
    output in_valid, opcode, cond, rd, reg_list, carry_flag, zero_flag,
    input  in_ready, reg_select, r7_select, reg_write, reg_addr, r7_write,
           mem_offset, lm_done
  );

  modport slave (
    input  in_valid, opcode, cond, rd, reg_list, carry_flag, zero_flag,
    output in_ready, reg_select, r7_select, reg_write, reg_addr, r7_write,
           mem_offset, lm_done
  );
endinterface

// File: rtl/write_back_ctrl_lm_bit_picker.sv
// lm_bit_picker: lowest-set-bit priority encoder for the LM register list.
//   list      in  8  remaining registers, bit i = Ri
//   index     out 3  number of the lowest set bit (0 when list is empty)
//   found     out 1  list has at least one set bit
//   remaining out 8  list with the lowest set bit cleared
module lm_bit_picker (
  input  logic [7:0] list,
  output logic [2:0] index,
  output logic       found,
  output logic [7:0] remaining
);

  logic [7:0] lowest_s;

  // Isolate the lowest set bit, then encode its position
  always_comb begin
    lowest_s  = list & ~(list - 8'd1);
    remaining = list & (list - 8'd1);
    found     = |list;
    index     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      index = index | ({3{lowest_s[i]}} & 3'(i));
    end
  end

endmodule

// File: rtl/write_back_ctrl.sv
// write_back_ctrl: write-back stage sequencer. Accepts one decoded
// instruction per handshake and, one cycle later, drives the general and R7
// write strobes, their source selects and the destination address. LM is
// expanded into one register write per cycle in ascending register order.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-low
//   bus   : write_back_ctrl_if.slave (handshake, operands, write-back controls)
module write_back_ctrl
  import wb_pkg::*;
(
  input logic               clk,
  input logic               reset,
  write_back_ctrl_if.slave  bus
);

  wb_state_e  state_r;
  logic [7:0] list_r;
  logic [1:0] reg_select_r;
  logic [1:0] r7_select_r;
  logic       reg_write_r;
  logic [2:0] reg_addr_r;
  logic       r7_write_r;
  logic [2:0] mem_offset_r;
  logic       lm_done_r;

  logic       in_ready_s;
  logic       accept_s;
  logic [7:0] pick_in_s;
  logic [2:0] pick_idx_s;
  logic       pick_found_s;
  logic [7:0] pick_rem_s;
  logic       lm_issue_s;
  logic       lm_last_s;
  logic [2:0] lm_off_s;
  logic       is_r7_s;
  logic       cond_ok_s;
  logic       dec_reg_we_s;
  logic [1:0] dec_reg_sel_s;
  logic       dec_r7_we_s;
  logic [1:0] dec_r7_sel_s;

  // In IDLE the picker looks at the incoming list so the first LM write
  // issues on the accept edge; in LM it walks the latched list.
  lm_bit_picker u_picker (
    .list      (pick_in_s),
    .index     (pick_idx_s),
    .found     (pick_found_s),
    .remaining (pick_rem_s)
  );

  // Handshake and LM issue control
  always_comb begin
    in_ready_s = (state_r == ST_IDLE);
    accept_s   = bus.in_valid & in_ready_s & reset;
    pick_in_s  = (state_r == ST_LM) ? list_r : bus.reg_list;
    lm_issue_s = (state_r == ST_LM) |
                 (accept_s & (bus.opcode == OP_LM) & pick_found_s);
    lm_last_s  = (pick_rem_s == 8'd0);
    lm_off_s   = (state_r == ST_LM) ? (mem_offset_r + 3'd1) : 3'd0;
  end

  // Single-instruction decode; rd=7 redirects the write to the R7 port
  always_comb begin
    is_r7_s       = (bus.rd == 3'd7);
    cond_ok_s     = cond_pass(bus.cond, bus.carry_flag, bus.zero_flag);
    dec_reg_we_s  = 1'b0;
    dec_reg_sel_s = REG_SEL_ALU;
    dec_r7_we_s   = 1'b0;
    dec_r7_sel_s  = R7_SEL_ALU;
    case (bus.opcode)
      OP_ADD, OP_NDU: begin
        dec_reg_we_s = cond_ok_s & ~is_r7_s;
        dec_r7_we_s  = cond_ok_s & is_r7_s;
      end
      OP_ADI: begin
        dec_reg_we_s = ~is_r7_s;
        dec_r7_we_s  = is_r7_s;
      end
      OP_LHI: begin
        dec_reg_we_s  = ~is_r7_s;
        dec_reg_sel_s = REG_SEL_IMM;
        dec_r7_we_s   = is_r7_s;
        dec_r7_sel_s  = R7_SEL_IMM;
      end
      OP_LW: begin
        dec_reg_we_s  = ~is_r7_s;
        dec_reg_sel_s = REG_SEL_MEM;
        dec_r7_we_s   = is_r7_s;
        dec_r7_sel_s  = R7_SEL_MEM;
      end
      OP_JAL: begin
        // Link to rd is dropped when rd=7: the branch target wins R7
        dec_reg_we_s  = ~is_r7_s;
        dec_reg_sel_s = REG_SEL_PCINC;
        dec_r7_we_s   = 1'b1;
        dec_r7_sel_s  = R7_SEL_PCIMM;
      end
      OP_JLR: begin
        dec_reg_we_s  = ~is_r7_s;
        dec_reg_sel_s = REG_SEL_PCINC;
        dec_r7_we_s   = 1'b1;
        dec_r7_sel_s  = R7_SEL_ALU;
      end
      OP_BEQ: begin
        dec_r7_we_s  = bus.zero_flag;
        dec_r7_sel_s = R7_SEL_PCIMM;
      end
      default: begin
        dec_reg_we_s = 1'b0;
        dec_r7_we_s  = 1'b0;
      end
    endcase
  end

  // FSM and registered write-back controls; strobes default low each cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      list_r       <= 8'd0;
      reg_select_r <= 2'd0;
      r7_select_r  <= 2'd0;
      reg_write_r  <= 1'b0;
      reg_addr_r   <= 3'd0;
      r7_write_r   <= 1'b0;
      mem_offset_r <= 3'd0;
      lm_done_r    <= 1'b0;
    end else begin
      reg_write_r <= 1'b0;
      r7_write_r  <= 1'b0;
      lm_done_r   <= 1'b0;
      if (lm_issue_s) begin
        if (pick_idx_s == 3'd7) begin
          r7_write_r  <= 1'b1;
          r7_select_r <= R7_SEL_MEM;
        end else begin
          reg_write_r  <= 1'b1;
          reg_select_r <= REG_SEL_MEM;
          reg_addr_r   <= pick_idx_s;
        end
        mem_offset_r <= lm_off_s;
        list_r       <= pick_rem_s;
        lm_done_r    <= lm_last_s;
        state_r      <= lm_last_s ? ST_IDLE : ST_LM;
      end else if (accept_s) begin
        // Empty-list LM lands here and decodes to no strobes
        reg_write_r <= dec_reg_we_s;
        r7_write_r  <= dec_r7_we_s;
        if (dec_reg_we_s) begin
          reg_select_r <= dec_reg_sel_s;
          reg_addr_r   <= bus.rd;
        end else begin
          reg_select_r <= reg_select_r;
        end
        if (dec_r7_we_s) begin
          r7_select_r <= dec_r7_sel_s;
        end else begin
          r7_select_r <= r7_select_r;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.reg_select = reg_select_r;
  assign bus.r7_select  = r7_select_r;
  assign bus.reg_write  = reg_write_r;
  assign bus.reg_addr   = reg_addr_r;
  assign bus.r7_write   = r7_write_r;
  assign bus.mem_offset = mem_offset_r;
  assign bus.lm_done    = lm_done_r;

endmodule

// File: tb/tb_write_back_ctrl.sv
// tb_write_back_ctrl: directed bench for write_back_ctrl. Inputs change #1
// after a rising edge; outputs are checked #1 after the next rising edge.
module tb_write_back_ctrl;
  import wb_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  write_back_ctrl_if bus ();

  write_back_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] c,
                       input logic [2:0] r, input logic [7:0] lst,
                       input logic cf, input logic zf);
    bus.in_valid   = v;
    bus.opcode     = op;
    bus.cond       = c;
    bus.rd         = r;
    bus.reg_list   = lst;
    bus.carry_flag = cf;
    bus.zero_flag  = zf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // strobes + handshake in one call
  task automatic chk_s(input string tag, input logic rw, input logic r7w,
                       input logic done, input logic rdy);
    check({tag, ".reg_write"}, {7'd0, bus.reg_write}, {7'd0, rw});
    check({tag, ".r7_write"},  {7'd0, bus.r7_write},  {7'd0, r7w});
    check({tag, ".lm_done"},   {7'd0, bus.lm_done},   {7'd0, done});
    check({tag, ".in_ready"},  {7'd0, bus.in_ready},  {7'd0, rdy});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(1'b1, OP_ADD, 2'b00, 3'd3, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst.reg_select", {6'd0, bus.reg_select}, 8'd0);
    check("rst.r7_select",  {6'd0, bus.r7_select},  8'd0);
    check("rst.reg_addr",   {5'd0, bus.reg_addr},   8'd0);
    check("rst.mem_offset", {5'd0, bus.mem_offset}, 8'd0);

    reset = 1'b1;
    // ADD rd=3 cond=carry, carry=1
    drive(1'b1, OP_ADD, 2'b10, 3'd3, 8'h00, 1'b1, 1'b0);
    tick();
    chk_s("add_c1", 1'b1, 1'b0, 1'b0, 1'b1);
    check("add_c1.addr", {5'd0, bus.reg_addr},   8'd3);
    check("add_c1.sel",  {6'd0, bus.reg_select}, 8'd1);
    // carry=0 -> no strobe, select/address hold
    drive(1'b1, OP_ADD, 2'b10, 3'd3, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("add_c0", 1'b0, 1'b0, 1'b0, 1'b1);
    check("add_c0.addr_hold", {5'd0, bus.reg_addr}, 8'd3);
    // ADD cond=zero with zero=1
    drive(1'b1, OP_ADD, 2'b01, 3'd1, 8'h00, 1'b0, 1'b1);
    tick();
    chk_s("add_z1", 1'b1, 1'b0, 1'b0, 1'b1);
    check("add_z1.addr", {5'd0, bus.reg_addr}, 8'd1);
    // NDU cond=never
    drive(1'b1, OP_NDU, 2'b11, 3'd2, 8'h00, 1'b1, 1'b1);
    tick();
    chk_s("ndu_never", 1'b0, 1'b0, 1'b0, 1'b1);
    // LHI rd=7
    drive(1'b1, OP_LHI, 2'b00, 3'd7, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("lhi_r7", 1'b0, 1'b1, 1'b0, 1'b1);
    check("lhi_r7.r7sel", {6'd0, bus.r7_select}, 8'd0);
    // JAL rd=2: link + branch same cycle
    drive(1'b1, OP_JAL, 2'b00, 3'd2, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("jal", 1'b1, 1'b1, 1'b0, 1'b1);
    check("jal.addr",  {5'd0, bus.reg_addr},   8'd2);
    check("jal.sel",   {6'd0, bus.reg_select}, 8'd3);
    check("jal.r7sel", {6'd0, bus.r7_select},  8'd2);
    // JLR rd=7: only the branch write
    drive(1'b1, OP_JLR, 2'b00, 3'd7, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("jlr_r7", 1'b0, 1'b1, 1'b0, 1'b1);
    check("jlr_r7.r7sel", {6'd0, bus.r7_select}, 8'd3);
    // LW rd=6
    drive(1'b1, OP_LW, 2'b00, 3'd6, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("lw", 1'b1, 1'b0, 1'b0, 1'b1);
    check("lw.addr", {5'd0, bus.reg_addr},   8'd6);
    check("lw.sel",  {6'd0, bus.reg_select}, 8'd0);
    // ADI rd=7 ignores cond=never
    drive(1'b1, OP_ADI, 2'b11, 3'd7, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("adi_r7", 1'b0, 1'b1, 1'b0, 1'b1);
    check("adi_r7.r7sel", {6'd0, bus.r7_select}, 8'd3);

    // LM 1000_0101, then an ADD waiting behind it
    drive(1'b1, OP_LM, 2'b00, 3'd0, 8'b1000_0101, 1'b0, 1'b0);
    tick();
    chk_s("lm1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("lm1.addr", {5'd0, bus.reg_addr},   8'd0);
    check("lm1.sel",  {6'd0, bus.reg_select}, 8'd0);
    check("lm1.off",  {5'd0, bus.mem_offset}, 8'd0);
    drive(1'b1, OP_ADD, 2'b00, 3'd5, 8'hFF, 1'b0, 1'b0);
    tick();
    chk_s("lm2", 1'b1, 1'b0, 1'b0, 1'b0);
    check("lm2.addr", {5'd0, bus.reg_addr},   8'd2);
    check("lm2.off",  {5'd0, bus.mem_offset}, 8'd1);
    tick();
    chk_s("lm3", 1'b0, 1'b1, 1'b1, 1'b1);
    check("lm3.r7sel", {6'd0, bus.r7_select},  8'd1);
    check("lm3.off",   {5'd0, bus.mem_offset}, 8'd2);
    tick();
    chk_s("lm_next_add", 1'b1, 1'b0, 1'b0, 1'b1);
    check("lm_next_add.addr", {5'd0, bus.reg_addr},   8'd5);
    check("lm_next_add.sel",  {6'd0, bus.reg_select}, 8'd1);

    // LM with empty list then ADD back-to-back
    drive(1'b1, OP_LM, 2'b00, 3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("lm_empty", 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, OP_ADD, 2'b00, 3'd4, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("lm_empty_add", 1'b1, 1'b0, 1'b0, 1'b1);
    check("lm_empty_add.addr", {5'd0, bus.reg_addr}, 8'd4);

    // LM 0xFF aborted by reset at N+3
    drive(1'b1, OP_LM, 2'b00, 3'd0, 8'hFF, 1'b0, 1'b0);
    tick();
    chk_s("lmff1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("lmff1.addr", {5'd0, bus.reg_addr}, 8'd0);
    drive(1'b0, OP_ADD, 2'b00, 3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("lmff2", 1'b1, 1'b0, 1'b0, 1'b0);
    check("lmff2.addr", {5'd0, bus.reg_addr},   8'd1);
    check("lmff2.off",  {5'd0, bus.mem_offset}, 8'd1);
    tick();
    chk_s("lmff3", 1'b1, 1'b0, 1'b0, 1'b0);
    check("lmff3.addr", {5'd0, bus.reg_addr},   8'd2);
    check("lmff3.off",  {5'd0, bus.mem_offset}, 8'd2);
    reset = 1'b0;
    tick();
    chk_s("lmff_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("lmff_rst.addr", {5'd0, bus.reg_addr},   8'd0);
    check("lmff_rst.off",  {5'd0, bus.mem_offset}, 8'd0);
    check("lmff_rst.sel",  {6'd0, bus.reg_select}, 8'd0);
    reset = 1'b1;
    tick();
    chk_s("lmff_after", 1'b0, 1'b0, 1'b0, 1'b1);

    // BEQ taken / not taken, SW
    drive(1'b1, OP_BEQ, 2'b00, 3'd0, 8'h00, 1'b0, 1'b1);
    tick();
    chk_s("beq_z1", 1'b0, 1'b1, 1'b0, 1'b1);
    check("beq_z1.r7sel", {6'd0, bus.r7_select}, 8'd2);
    drive(1'b1, OP_BEQ, 2'b00, 3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("beq_z0", 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, OP_SW, 2'b00, 3'd3, 8'h00, 1'b1, 1'b1);
    tick();
    chk_s("sw", 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, OP_ADD, 2'b00, 3'd3, 8'h00, 1'b0, 1'b0);
    tick();
    chk_s("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
